aes256_encrypt_core: RTL and testbench

- Iterative AES-256 encryption datapath, one round per clock; the forward counterpart of the decryption path.
- Applies initial AddRoundKey, then rounds 1..NR of SubBytes → ShiftRows → MixColumns → AddRoundKey. The final round skips MixColumns.
- Round keys come from an external key-expansion store, indexed by this block.
- Valid/ready handshake on both input and output.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_enc_round.sv | 59 +++++
 rtl/aes256_encrypt_core.sv | 93 +++++++++
 tb/tb_aes256_encrypt_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, S-box, GF(2^8) helper and FSM encoding.
// Used by the encrypt core and its round datapath.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } enc_state_e;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports: state_in, round_key, last_round (skip MixColumns) -> state_out.
module aes_enc_round
    import aes_pkg::*;
(
    input  aes_state_t state_in,
    input  aes_state_t round_key,
    input  logic       last_round,
    output aes_state_t state_out
);

    // Byte index i = 4*col + row; byte 0 is the MSB.
    aes_byte_t sb [16];
    aes_byte_t sr [16];
    aes_byte_t mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_in[127-8*i -: 8]];
        end
    end

    // Row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
    end

    always_comb begin
        aes_byte_t a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1
                      ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2)
                      ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2)
                      ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2
                      ^ xtime(a3);
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[127-8*i -: 8] =
                (last_round ? sr[i] : mc[i])
                ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes256_encrypt_core.sv
// Iterative AES encryption core, one round per clock, FSM IDLE/ROUND/DONE.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/plaintext;
//   rk_idx/rk (external round-key store, combinational lookup);
//   out_valid/out_ready/ciphertext; busy.
// Build option AES_ENC_ZEROIZE_EN: wipe state and ciphertext on the
//   output handshake, so ciphertext reads 0 while out_valid is low.
module aes256_encrypt_core
    import aes_pkg::*;
#(
    parameter int NR = AES256_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    enc_state_e fsm;
    aes_state_t state_q;
    aes_state_t round_out;
    logic [3:0] round_q;
    logic       last_round;

    assign last_round = (round_q == 4'(NR));

    aes_enc_round u_round (
        .state_in   (state_q),
        .round_key  (rk),
        .last_round (last_round),
        .state_out  (round_out)
    );

    // rk_idx is registered alongside round_q so it always
    // names the key the current cycle's round consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            state_q    <= '0;
            round_q    <= '0;
            rk_idx     <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ciphertext <= '0;
        end else begin
            unique case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q  <= plaintext ^ rk;
                        round_q  <= 4'd1;
                        rk_idx   <= 4'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_q <= round_out;
                    if (last_round) begin
                        ciphertext <= round_out;
                        out_valid  <= 1'b1;
                        rk_idx     <= '0;
                        fsm        <= ST_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        rk_idx  <= round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= ST_IDLE;
`ifdef AES_ENC_ZEROIZE_EN
                        state_q    <= '0;
                        ciphertext <= '0;
`endif
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Self-checking bench for aes256_encrypt_core against a
// byte-array AES model with its own key expansion and S-box.
module tb_aes256_encrypt_core;

    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_mem [15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk = (rk_idx < 4'd15) ? rk_mem[rk_idx] : '0;

    aes256_encrypt_core #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse by search, then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                 ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]],
                sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++)
            rk_mem[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd == NR) begin
                        s[4*c+r] = t[4*c+r];
                    end else begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++)
                            acc ^= gmul(coef[(k-r+4)%4], t[4*c+k]);
                        s[4*c+r] = acc;
                    end
                end
            for (int i = 0; i < 16; i++)
                s[i] ^= rk_mem[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int t_valid;

    task automatic send(input logic [255:0] key,
                        input logic [127:0] pt,
                        output logic [127:0] ct);
        logic [127:0] exp;
        int n;
        expand(key);
        exp = model_enc(pt);
        plaintext = pt;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 128'(in_ready), 128'(1));
        check("rk_idx_idle", 128'(rk_idx), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        plaintext = rand128();
        check("busy_round", 128'(busy), 128'(1));
        check("in_ready_round", 128'(in_ready), 128'(0));
        n = 0;
        while (!out_valid && n < 40) begin
            check("rk_idx_seq", 128'(rk_idx), 128'(n + 1));
            @(posedge clk); #1;
            n++;
        end
        check("latency", 128'(n), 128'(NR));
        t_valid = cyc;
        check("ct_model", ciphertext, exp);
        ct = ciphertext;
    endtask

    task automatic finish_out(input int hold,
                              input logic [127:0] ct);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            plaintext = rand128();
            @(posedge clk); #1;
            check("bp_ct", ciphertext, ct);
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 128'(in_ready), 128'(1));
        check("idle_out_valid", 128'(out_valid), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
`ifdef AES_ENC_ZEROIZE_EN
        check("post_ct", ciphertext, 128'(0));
`else
        check("post_ct", ciphertext, ct);
`endif
    endtask

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3 =
        128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 =
        128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_Z =
        128'hdc95c078a2408989ad48a21492842087;

    initial begin
        logic [127:0] ct;
        int t1;
        int hold;
        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
        expand('0);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_ct", ciphertext, 128'(0));
        rst = 1'b0;

        // FIPS-197 C.3 with 20 cycles of backpressure
        out_ready = 1'b0;
        send(KEY_C3, PT_C3, ct);
        check("c3_fips", ct, CT_C3);
        finish_out(20, ct);

        // Reset while round 7 is in flight
        out_ready = 1'b1;
        expand(KEY_C3);
        plaintext = PT_C3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rk_idx", 128'(rk_idx), 128'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_in_ready", 128'(in_ready), 128'(1));
        check("mid_out_valid", 128'(out_valid), 128'(0));
        check("mid_rk_idx0", 128'(rk_idx), 128'(0));
        check("mid_busy", 128'(busy), 128'(0));
        send(KEY_C3, PT_C3, ct);
        check("c3_after_rst", ct, CT_C3);
        finish_out(0, ct);

        // Back-to-back with out_ready high
        out_ready = 1'b1;
        send(KEY_C3, PT_C3, ct);
        check("b2b_first", ct, CT_C3);
        t1 = t_valid;
        finish_out(0, ct);
        send('0, '0, ct);
        check("b2b_zero", ct, CT_Z);
        check("b2b_gap", 128'(t_valid - t1), 128'(NR + 2));
        finish_out(0, ct);

        // Random keys and blocks, random backpressure
        for (int k = 0; k < 6; k++) begin
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            send({rand128(), rand128()}, rand128(), ct);
            finish_out(hold, ct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
